// File: rtl/arith_divf_result_stage.sv
// arith_divf_result_stage: classifies IEEE-754 divide exceptions, canonicalises NaN
// quotients and buffers {flags, result} in a small FIFO with a sticky flag register.
module arith_divf_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH-1:0]         in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,
    output logic [3:0]               sticky_flags,
    input  logic                     flags_clear,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int EW = (WIDTH == 64) ? 11 : 8;
    localparam int MW = WIDTH - 1 - EW;
    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $fatal(1, "arith_divf_result_stage: WIDTH must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "arith_divf_result_stage: DEPTH must be a power of two >= 2");
    end

    // Class vector: {snan, nan, inf, zero, sub}
    function automatic logic [4:0] classify(input logic [WIDTH-1:0] x);
        logic e_ones, e_zero, m_zero;
        e_ones = &x[WIDTH-2:MW];
        e_zero = ~|x[WIDTH-2:MW];
        m_zero = ~|x[MW-1:0];
        return {e_ones & ~m_zero & ~x[MW-1], e_ones & ~m_zero, e_ones & m_zero,
                e_zero & m_zero, e_zero & ~m_zero};
    endfunction

    logic [4:0]       w_ca, w_cb, w_cr;
    logic             w_fin_a, w_fin_b;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_res;
    logic             w_push, w_pop;

    logic [WIDTH+3:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic [3:0]       r_sticky;

    always_comb begin
        w_ca    = classify(in_a);
        w_cb    = classify(in_b);
        w_cr    = classify(in_result);
        w_fin_a = ~(w_ca[3] | w_ca[2]);
        w_fin_b = ~(w_cb[3] | w_cb[2]);
        w_flags = {(w_ca[1] & w_cb[1]) | (w_ca[2] & w_cb[2]) | w_ca[4] | w_cb[4],
                   w_cb[1] & w_fin_a & ~w_ca[1],
                   w_cr[2] & w_fin_a & w_fin_b & ~w_cb[1],
                   (w_cr[1] | w_cr[0]) & w_fin_a & ~w_ca[1] & w_fin_b & ~w_cb[1]};
        w_res   = w_cr[3] ? QNAN : in_result;
    end

    assign in_ready     = r_count != (AW+1)'(DEPTH);
    assign out_valid    = r_count != '0;
    assign w_push       = in_valid & in_ready;
    assign w_pop        = out_valid & out_ready;
    assign {out_flags, out_result} = out_valid ? r_mem[r_rptr] : '0;
    assign sticky_flags = r_sticky;
    assign count        = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_flags, w_res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_sticky <= '0;
        end else begin
            r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
            r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            // A clear coinciding with a pop keeps only the popped entry's flags
            if (w_pop) r_sticky <= (flags_clear ? 4'b0 : r_sticky) | out_flags;
            else if (flags_clear) r_sticky <= 4'b0;
        end
    end
endmodule

// File: tb/tb_arith_divf_result_stage.sv
// tb_arith_divf_result_stage: random and directed stimulus against a queue-based
// reference model of the divider result stage; a WIDTH=64 instance gets a short rerun.
module tb_arith_divf_result_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, flags_clear;
    logic [31:0] in_a, in_b, in_result, out_result;
    logic [3:0]  out_flags, sticky_flags;
    logic [1:0]  count;

    logic        in_valid_d, in_ready_d, out_valid_d, out_ready_d, flags_clear_d;
    logic [63:0] in_a_d, in_b_d, in_result_d, out_result_d;
    logic [3:0]  out_flags_d, sticky_flags_d;
    logic [1:0]  count_d;

    arith_divf_result_stage #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_result(in_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .flags_clear(flags_clear), .count(count));

    arith_divf_result_stage #(.WIDTH(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .in_a(in_a_d), .in_b(in_b_d), .in_result(in_result_d), .out_valid(out_valid_d),
        .out_ready(out_ready_d), .out_result(out_result_d), .out_flags(out_flags_d),
        .sticky_flags(sticky_flags_d), .flags_clear(flags_clear_d), .count(count_d));

    typedef struct {logic [31:0] r; logic [3:0] f;} ent_t;
    ent_t       q[$];
    logic [3:0] m_sticky = 4'b0;
    int         checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // 0 zero, 1 subnormal, 2 normal, 3 inf, 4 quiet NaN, 5 signalling NaN
    function automatic int fclass(input logic [63:0] x, input int ew, input int mw);
        logic [63:0] e, m;
        e = (x >> mw) & ((64'd1 << ew) - 1);
        m = x & ((64'd1 << mw) - 1);
        if (e == (64'd1 << ew) - 1) return (m == 0) ? 3 : (m[mw-1] ? 4 : 5);
        return (e == 0) ? ((m == 0) ? 0 : 1) : 2;
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] a, b, r);
        int  ca, cb, cr;
        logic fa, fb;
        ca = fclass({32'b0, a}, 8, 23);
        cb = fclass({32'b0, b}, 8, 23);
        cr = fclass({32'b0, r}, 8, 23);
        fa = ca <= 2;
        fb = cb <= 2;
        return {(ca == 0 && cb == 0) || (ca == 3 && cb == 3) || ca == 5 || cb == 5,
                cb == 0 && fa && ca != 0,
                cr == 3 && fa && fb && cb != 0,
                cr <= 1 && fa && ca != 0 && fb && cb != 0};
    endfunction

    function automatic logic [31:0] mk(input int k);
        logic        s;
        logic [22:0] m;
        s = 1'($urandom);
        m = 23'($urandom);
        case (k)
            0: return {s, 31'b0};
            1: return {s, 8'h00, m | 23'd1};
            3: return {s, 8'hFF, 23'b0};
            4: return {s, 8'hFF, 1'b1, m[21:0]};
            5: return {s, 8'hFF, 1'b0, m[21:0] | 22'd1};
            default: return {s, 8'($urandom_range(1, 254)), m};
        endcase
    endfunction

    task automatic verify();
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("sticky", 64'(sticky_flags), 64'(m_sticky));
        if (q.size() != 0) begin
            chk("head_result", 64'(out_result), 64'(q[0].r));
            chk("head_flags", 64'(out_flags), 64'(q[0].f));
        end else begin
            chk("idle_result", 64'(out_result), 64'd0);
            chk("idle_flags", 64'(out_flags), 64'd0);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] a, b, r, input logic ordy, clr);
        logic [3:0] f;
        logic       push, pop;
        @(negedge clk);
        verify();
        in_valid = v; in_a = a; in_b = b; in_result = r; out_ready = ordy; flags_clear = clr;
        pop  = ordy && q.size() > 0;
        push = v && q.size() < DEPTH;
        if (pop) begin
            f = q[0].f;
            void'(q.pop_front());
            m_sticky = (clr ? 4'b0 : m_sticky) | f;
        end else if (clr) m_sticky = 4'b0;
        if (push) q.push_back('{(fclass({32'b0, r}, 8, 23) >= 4) ? 32'h7FC00000 : r, ref_flags(a, b, r)});
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 0; in_a = 0; in_b = 0; in_result = 0; out_ready = 0; flags_clear = 0;
        in_valid_d = 0; in_a_d = 0; in_b_d = 0; in_result_d = 0; out_ready_d = 0; flags_clear_d = 0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        #10 rst_n = 1'b1;

        step(1, 32'h40C00000, 32'h40000000, 32'h40400000, 1, 0);
        settle();
        chk("basic_result", 64'(out_result), 64'h40400000);
        chk("basic_flags", 64'(out_flags), 64'h0);
        chk("basic_count", 64'(count), 64'd1);
        step(0, 0, 0, 0, 1, 0);
        settle();
        chk("basic_drained", 64'(count), 64'd0);

        step(1, 32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0);
        settle();
        chk("dz_flags", 64'(out_flags), 64'b0100);
        step(1, 32'h00000000, 32'h00000000, 32'hFFC00001, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        settle();
        chk("nan_result", 64'(out_result), 64'h7FC00000);
        chk("nan_flags", 64'(out_flags), 64'b1000);
        step(0, 0, 0, 0, 1, 0);
        settle();
        chk("sticky_nv_dz", 64'(sticky_flags), 64'b1100);

        step(1, 32'h7F000000, 32'h3E800000, 32'h7F800000, 1, 0);
        settle();
        chk("of_flags", 64'(out_flags), 64'b0010);
        step(1, 32'h00800000, 32'h40000000, 32'h00400000, 1, 0);
        settle();
        chk("uf_flags", 64'(out_flags), 64'b0001);
        step(1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1, 0);
        settle();
        chk("inf_flags", 64'(out_flags), 64'b0000);
        step(0, 0, 0, 0, 1, 0);

        step(0, 0, 0, 0, 0, 1);
        settle();
        chk("clear_idle", 64'(sticky_flags), 64'b0000);
        step(1, 32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0);
        step(1, 32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0);
        step(1, 32'h40000000, 32'h00000000, 32'h7F800000, 1, 0);
        settle();
        chk("sticky_pre_clear", 64'(sticky_flags), 64'b1100);
        step(0, 0, 0, 0, 1, 1);
        settle();
        chk("clear_with_pop", 64'(sticky_flags), 64'b0100);
        step(0, 0, 0, 0, 0, 1);
        settle();
        chk("clear_no_pop", 64'(sticky_flags), 64'b0000);

        step(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0);
        step(1, 32'h40000000, 32'h3F800000, 32'h40000000, 0, 0);
        step(1, 32'h40400000, 32'h3F800000, 32'h40400000, 0, 0);
        settle();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_count", 64'(count), 64'd2);
        step(1, 32'h40400000, 32'h3F800000, 32'h40400000, 1, 0);
        settle();
        chk("bp_second", 64'(out_result), 64'h40000000);
        step(1, 32'h40400000, 32'h3F800000, 32'h40400000, 1, 0);
        settle();
        chk("bp_third", 64'(out_result), 64'h40400000);
        step(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb, rr;
            ra = mk(($urandom % 2 == 0) ? 2 : int'($urandom_range(0, 5)));
            rb = mk(($urandom % 2 == 0) ? 2 : int'($urandom_range(0, 5)));
            rr = mk(($urandom % 2 == 0) ? 2 : int'($urandom_range(0, 5)));
            step(1'($urandom % 4 != 0), ra, rb, rr, 1'($urandom % 3 != 0), 1'($urandom % 10 == 0));
        end

        step(1, 32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0);
        step(1, 32'h3F800000, 32'h00000000, 32'hFF800000, 1, 0);
        settle();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_sticky", 64'(sticky_flags), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        m_sticky = 4'b0;
        #1 rst_n = 1'b1;
        step(1, 32'h40800000, 32'h40000000, 32'h40000000, 1, 0);
        settle();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_result", 64'(out_result), 64'h40000000);
        step(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        verify();
        in_valid = 0;

        in_valid_d = 1; in_a_d = 64'h3FF0000000000000; in_b_d = 64'h0;
        in_result_d = 64'h7FF0000000000000; out_ready_d = 1;
        settle();
        chk("w64_dz_valid", 64'(out_valid_d), 64'd1);
        chk("w64_dz_flags", 64'(out_flags_d), 64'b0100);
        chk("w64_dz_result", out_result_d, 64'h7FF0000000000000);
        @(negedge clk);
        in_a_d = 64'h0; in_b_d = 64'h0; in_result_d = 64'hFFF8000000000001;
        settle();
        chk("w64_nan_flags", 64'(out_flags_d), 64'b1000);
        chk("w64_nan_result", out_result_d, 64'h7FF8000000000000);
        @(negedge clk);
        in_valid_d = 0;
        settle();
        chk("w64_count", 64'(count_d), 64'd0);
        chk("w64_sticky", 64'(sticky_flags_d), 64'b1100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
